// File: rtl/lfsr_stream_gen_if.sv
// ============================================================================
// Module      : lfsr_stream_gen_if
// Description : valid/ready word stream carrying LFSR output to its consumer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lfsr_stream_gen_if #(
    parameter int OUT_W = 32
);
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

`default_nettype wire

// File: rtl/lfsr_stream_gen.sv
// ============================================================================
// Module      : lfsr_stream_gen
// Description : Fibonacci LFSR word generator, STEP shifts per word, with seed
//               reload, all-zero lock-up recovery and accepted-word counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_stream_gen #(
    parameter int          WIDTH = 64,
    parameter logic [63:0] POLY  = 64'hD800_0000_0000_0000,
    parameter logic [63:0] SEED  = 64'h5083_e3e3_8587_694b,
    parameter int          STEP  = 8,
    parameter int          OUT_W = 32
) (
    input  logic               clk,
    input  logic               rs_n,
    input  logic               en,
    input  logic               seed_load,
    input  logic [WIDTH-1:0]   seed_in,
    lfsr_stream_gen_if.master  out_if,
    output logic               lockup,
    output logic [31:0]        word_cnt
);

    localparam logic [WIDTH-1:0] c_TAPS    = POLY[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_SEED    = SEED[WIDTH-1:0];
    localparam logic [31:0]      c_CNT_MAX = 32'hFFFF_FFFF;

    logic [WIDTH-1:0] r_state;
    logic             r_valid;
    logic [OUT_W-1:0] r_data;
    logic             r_lockup;
    logic [31:0]      r_cnt;

    logic [WIDTH-1:0] w_adv;
    logic             w_gen;
    logic             w_hs;
    logic             w_adv_zero;
    logic             w_seed_zero;

    // STEP single shifts unrolled into one combinational advance
    always_comb begin
        w_adv = r_state;
        for (int i = 0; i < STEP; i++) begin
            w_adv = {w_adv[WIDTH-2:0], ^(w_adv & c_TAPS)};
        end
    end

    assign w_hs        = r_valid & out_if.out_ready;
    assign w_gen       = en & ~seed_load & (~r_valid | out_if.out_ready);
    assign w_adv_zero  = (w_adv == '0);
    assign w_seed_zero = (seed_in == '0);

    always_ff @(posedge clk or negedge rs_n) begin
        if (!rs_n) begin
            r_state  <= c_SEED;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_lockup <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_lockup <= 1'b0;

            if (w_hs && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 32'd1;
            end

            if (seed_load) begin
                // Reload drops the presented word; out_data keeps its old value
                r_valid <= 1'b0;
                if (w_seed_zero) begin
                    r_state  <= c_SEED;
                    r_lockup <= 1'b1;
                end else begin
                    r_state <= seed_in;
                end
            end else if (w_gen) begin
                r_valid <= 1'b1;
                r_data  <= w_adv[OUT_W-1:0];
                if (w_adv_zero) begin
                    r_state  <= c_SEED;
                    r_lockup <= 1'b1;
                end else begin
                    r_state <= w_adv;
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_if.out_valid = r_valid;
    assign out_if.out_data  = r_data;
    assign lockup           = r_lockup;
    assign word_cnt         = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_stream_gen.sv
// ============================================================================
// Module      : tb_lfsr_stream_gen
// Description : self-checking bench for lfsr_stream_gen (8-bit and default).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_stream_gen;

    localparam logic [63:0] c_POLY8  = 64'h0000_0000_0000_00B8;
    localparam logic [63:0] c_SEED8  = 64'h0000_0000_0000_0001;
    localparam logic [63:0] c_POLY64 = 64'hD800_0000_0000_0000;
    localparam logic [63:0] c_SEED64 = 64'h5083_e3e3_8587_694b;

    logic clk  = 1'b0;
    logic rs_n = 1'b0;
    always #5 clk = ~clk;

    logic        en8 = 1'b0, sl8 = 1'b0;
    logic [7:0]  si8 = '0;
    logic        lk8;
    logic [31:0] cnt8;
    logic        en64 = 1'b0, sl64 = 1'b0;
    logic [63:0] si64 = '0;
    logic        lk64;
    logic [31:0] cnt64;

    lfsr_stream_gen_if #(.OUT_W(8))  if8 ();
    lfsr_stream_gen_if #(.OUT_W(32)) if64 ();

    lfsr_stream_gen #(
        .WIDTH(8), .POLY(c_POLY8), .SEED(c_SEED8), .STEP(1), .OUT_W(8)
    ) dut8 (
        .clk(clk), .rs_n(rs_n), .en(en8), .seed_load(sl8), .seed_in(si8),
        .out_if(if8), .lockup(lk8), .word_cnt(cnt8)
    );

    lfsr_stream_gen dut64 (
        .clk(clk), .rs_n(rs_n), .en(en64), .seed_load(sl64), .seed_in(si64),
        .out_if(if64), .lockup(lk64), .word_cnt(cnt64)
    );

    int n_vec = 0;
    int n_bad = 0;

    // Reference: the generator viewed as a bit sequence obeying the tap recurrence
    int          m_w[2]    = '{8, 64};
    int          m_step[2] = '{1, 8};
    int          m_ow[2]   = '{8, 32};
    logic [63:0] m_poly[2];
    logic [63:0] m_seed[2];
    bit          hist[2][$];
    bit          m_valid[2];
    logic [63:0] m_data[2];
    bit          m_lock[2];
    logic [31:0] m_cnt[2];

    function automatic void m_load(input int id, input logic [63:0] s);
        hist[id].delete();
        for (int k = m_w[id] - 1; k >= 0; k--) hist[id].push_back(s[k]);
    endfunction

    function automatic logic [63:0] m_window(input int id, input int n);
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < n; k++) v[k] = hist[id][hist[id].size() - 1 - k];
        return v;
    endfunction

    function automatic void m_extend(input int id);
        bit b;
        for (int j = 0; j < m_step[id]; j++) begin
            b = 1'b0;
            for (int k = 0; k < m_w[id]; k++)
                if (m_poly[id][k]) b ^= hist[id][hist[id].size() - 1 - k];
            hist[id].push_back(b);
            void'(hist[id].pop_front());
        end
    endfunction

    function automatic void m_reset(input int id);
        m_load(id, m_seed[id]);
        m_valid[id] = 1'b0;
        m_data[id]  = '0;
        m_lock[id]  = 1'b0;
        m_cnt[id]   = '0;
    endfunction

    function automatic void m_edge(input int id, input bit en, input bit rdy,
                                   input bit sl, input logic [63:0] si);
        bit hs;
        hs = m_valid[id] && rdy;
        m_lock[id] = 1'b0;
        if (hs && m_cnt[id] != 32'hFFFF_FFFF) m_cnt[id] = m_cnt[id] + 1;
        if (sl) begin
            m_valid[id] = 1'b0;
            if (si == '0) begin
                m_load(id, m_seed[id]);
                m_lock[id] = 1'b1;
            end else begin
                m_load(id, si);
            end
        end else if (en && (!m_valid[id] || rdy)) begin
            m_extend(id);
            m_data[id]  = m_window(id, m_ow[id]);
            m_valid[id] = 1'b1;
            if (m_window(id, m_w[id]) == '0) begin
                m_load(id, m_seed[id]);
                m_lock[id] = 1'b1;
            end
        end else if (hs) begin
            m_valid[id] = 1'b0;
        end
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("d8.valid",  {63'd0, if8.out_valid},  {63'd0, m_valid[0]});
        check("d8.data",   {56'd0, if8.out_data},   m_data[0]);
        check("d8.lockup", {63'd0, lk8},            {63'd0, m_lock[0]});
        check("d8.cnt",    {32'd0, cnt8},           {32'd0, m_cnt[0]});
        check("d64.valid", {63'd0, if64.out_valid}, {63'd0, m_valid[1]});
        check("d64.data",  {32'd0, if64.out_data},  m_data[1]);
        check("d64.lockup",{63'd0, lk64},           {63'd0, m_lock[1]});
        check("d64.cnt",   {32'd0, cnt64},          {32'd0, m_cnt[1]});
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rs_n) begin
            m_reset(0);
            m_reset(1);
        end else begin
            m_edge(0, en8, if8.out_ready, sl8, {56'd0, si8});
            m_edge(1, en64, if64.out_ready, sl64, si64);
        end
        #1;
        compare_all();
    endtask

    task automatic reset_all();
        en8 = 1'b0; sl8 = 1'b0; si8 = '0; if8.out_ready = 1'b0;
        en64 = 1'b0; sl64 = 1'b0; si64 = '0; if64.out_ready = 1'b0;
        rs_n = 1'b0;
        m_reset(0);
        m_reset(1);
        cycle();
        rs_n = 1'b1;
    endtask

    typedef struct {
        bit          en;
        bit          ready;
        bit          exp_valid;
        logic [7:0]  exp_data;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t        t1[10];
    logic [7:0]  w8[256];
    logic [31:0] ref64[4];
    logic [31:0] held;
    logic [31:0] cnt_before;
    int          first_rep;

    initial begin
        m_poly[0] = c_POLY8;  m_seed[0] = c_SEED8;
        m_poly[1] = c_POLY64; m_seed[1] = c_SEED64;
        if8.out_ready  = 1'b0;
        if64.out_ready = 1'b0;

        t1[0] = '{0, 1, 0, 8'h00, 0};
        t1[1] = '{1, 1, 1, 8'h02, 0};
        t1[2] = '{1, 1, 1, 8'h04, 1};
        t1[3] = '{1, 0, 1, 8'h04, 1};
        t1[4] = '{0, 0, 1, 8'h04, 1};
        t1[5] = '{0, 1, 0, 8'h04, 2};
        t1[6] = '{1, 1, 1, 8'h08, 2};
        t1[7] = '{1, 1, 1, 8'h11, 3};
        t1[8] = '{1, 1, 1, 8'h23, 4};
        t1[9] = '{1, 1, 1, 8'h47, 5};

        // Reset state and 8-bit stream table
        reset_all();
        for (int i = 0; i < 10; i++) begin
            en8 = t1[i].en;
            if8.out_ready = t1[i].ready;
            cycle();
            check($sformatf("T1.valid[%0d]", i), {63'd0, if8.out_valid}, {63'd0, t1[i].exp_valid});
            check($sformatf("T1.data[%0d]", i),  {56'd0, if8.out_data},  {56'd0, t1[i].exp_data});
            check($sformatf("T1.cnt[%0d]", i),   {32'd0, cnt8},          {32'd0, t1[i].exp_cnt});
        end

        // Full period of the 8-bit generator
        reset_all();
        en8 = 1'b1; if8.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cycle();
            w8[i] = m_data[0][7:0];
            check("T2.nonzero", {63'd0, (if8.out_data == 8'h00)}, 64'd0);
        end
        first_rep = 0;
        for (int i = 255; i >= 1; i--) if (w8[i] == w8[0]) first_rep = i;
        check("T2.first", {56'd0, w8[0]}, 64'h02);
        check("T2.period", first_rep, 255);
        en8 = 1'b0;

        // Default config: hold under backpressure, then resume
        reset_all();
        en64 = 1'b1; if64.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            ref64[i] = m_data[1][31:0];
        end
        if64.out_ready = 1'b0;
        held = ref64[3];
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("T3.hold_data", {32'd0, if64.out_data}, {32'd0, held});
            check("T3.hold_valid", {63'd0, if64.out_valid}, 64'd1);
        end
        if64.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) cycle();

        // Zero seed reload falls back to SEED with a lock-up pulse
        sl64 = 1'b1; si64 = '0;
        cycle();
        sl64 = 1'b0;
        check("T4.lockup", {63'd0, lk64}, 64'd1);
        check("T4.valid", {63'd0, if64.out_valid}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("T4.lockup_clear", {63'd0, lk64}, 64'd0);
            check($sformatf("T4.word[%0d]", i), {32'd0, if64.out_data}, {32'd0, ref64[i]});
        end

        // Seed reload coinciding with a handshake
        cnt_before = m_cnt[1];
        sl64 = 1'b1; si64 = 64'h1234;
        cycle();
        sl64 = 1'b0;
        check("T5.cnt", {32'd0, cnt64}, {32'd0, cnt_before + 32'd1});
        cycle();
        check("T5.first_word", {32'd0, if64.out_data}, 64'h0012_3400);
        for (int i = 0; i < 5; i++) cycle();

        // Randomized traffic on both generators
        for (int i = 0; i < 300; i++) begin
            en8  = ($urandom_range(0, 3) != 0);
            if8.out_ready = $urandom_range(0, 1) != 0;
            sl8  = ($urandom_range(0, 31) == 0);
            si8  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            en64 = ($urandom_range(0, 3) != 0);
            if64.out_ready = $urandom_range(0, 1) != 0;
            sl64 = ($urandom_range(0, 31) == 0);
            si64 = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'($urandom), 32'($urandom)};
            cycle();
        end
        sl8 = 1'b0; sl64 = 1'b0;

        // Asynchronous reset while a word is held
        en64 = 1'b1; if64.out_ready = 1'b1;
        cycle();
        if64.out_ready = 1'b0;
        cycle();
        #3;
        rs_n = 1'b0;
        m_reset(0);
        m_reset(1);
        #1;
        check("T6.async_valid", {63'd0, if64.out_valid}, 64'd0);
        check("T6.async_cnt", {32'd0, cnt64}, 64'd0);
        check("T6.async_data", {32'd0, if64.out_data}, 64'd0);
        cycle();
        rs_n = 1'b1;
        en8 = 1'b0; en64 = 1'b1; if64.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check($sformatf("T6.word[%0d]", i), {32'd0, if64.out_data}, {32'd0, ref64[i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
